// File: rtl/video_ctrl_pkg.sv
// Shared definitions for the video timing controller.
// Contents:
//   state_t        controller state encoding (IDLE, RESET, WAIT_LOCK, RUN, DRAIN)
//   DEF_*          default generator reset length and frame watchdog limit
//   clog2()        counter width helper, never returns less than 1
package video_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  localparam int unsigned DEF_RST_CYCLES = 16;
  localparam int unsigned DEF_TIMEOUT    = 3000000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Vertical sync active-edge detector.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   vs_in     vs from the timing generator, synchronous to clk
//   vs_edge   one-cycle pulse, combinational, on the active edge of vs_in
// The delayed copy resets to "active" so a vs that is already active when
// reset is released does not register as an edge.
module vs_edge_detect #(
  parameter logic VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_in,
  output logic vs_edge
);

  logic vs_n;
  logic vs_d;

  always_comb begin
    vs_n    = VS_POL ? vs_in : ~vs_in;
    vs_edge = vs_n & ~vs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_d <= 1'b1;
    else     vs_d <= vs_n;
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Video timing generator sequencer.
// Holds the generator in reset, releases it, waits for LOCK_FRAMES vs edges,
// then runs with a per-frame watchdog. Mode changes requested in RUN are
// deferred to the next frame boundary (DRAIN) and applied via a fresh reset.
// Ports:
//   clk, rst      pixel clock, asynchronous active-high reset
//   enable        1 = run generator, 0 = force IDLE
//   mode_req      requested mode, mode_stb samples it (RUN/DRAIN only)
//   err_clr       clears sticky timeout_err
//   vs_in         vs from generator (polarity VS_POL)
//   gen_rst       generator reset
//   mode_sel      applied mode
//   video_ready   timing locked (RUN, DRAIN)
//   busy          RESET, WAIT_LOCK or DRAIN
//   timeout_err   sticky watchdog error
//   frame_cnt     vs edges counted in RUN/DRAIN, wraps
module video_timing_ctrl
  import video_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter logic        VS_POL      = 1'b1,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_stb,
  input  logic              err_clr,
  input  logic              vs_in,
  output logic              gen_rst,
  output logic [MODE_W-1:0] mode_sel,
  output logic              video_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned WD_W = clog2(TIMEOUT);
  localparam int unsigned RC_W = clog2(RST_CYCLES + 1);
  localparam int unsigned LK_W = clog2(LOCK_FRAMES + 1);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_FRAMES - 1);

  state_t            state;
  state_t            next;
  logic [RC_W-1:0]   rcnt;
  logic [LK_W-1:0]   lock_cnt;
  logic [WD_W-1:0]   wdog;
  logic [MODE_W-1:0] pending;

  logic vs_edge;
  logic watched;
  logic wd_last;
  logic expire;
  logic stb_take;

  vs_edge_detect #(.VS_POL(VS_POL)) u_vs_edge (
    .clk     (clk),
    .rst     (rst),
    .vs_in   (vs_in),
    .vs_edge (vs_edge)
  );

  // Priority: enable=0 > vs_edge > watchdog expiry > mode_stb.
  always_comb begin
    watched  = (state == WAIT_LOCK) || (state == RUN) || (state == DRAIN);
    wd_last  = (wdog == WD_LAST);
    expire   = enable && watched && wd_last && !vs_edge;
    stb_take = enable && mode_stb && !vs_edge && !(watched && wd_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    if (!enable) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:      next = RESET;
        RESET:     if (rcnt == RC_LAST) next = WAIT_LOCK;
        WAIT_LOCK: begin
          if (vs_edge) begin
            if (lock_cnt == LK_LAST) next = RUN;
          end else if (wd_last) begin
            next = RESET;
          end
        end
        RUN: begin
          if (!vs_edge) begin
            if (wd_last) next = RESET;
            else if (mode_stb && mode_req != mode_sel) next = DRAIN;
          end
        end
        DRAIN:     if (vs_edge || wd_last) next = RESET;
        default:   next = IDLE;
      endcase
    end
  end

  always_comb begin
    gen_rst     = 1'b0;
    busy        = 1'b0;
    video_ready = 1'b0;
    case (state)
      IDLE:      gen_rst = 1'b1;
      RESET:     begin gen_rst = 1'b1; busy = 1'b1; end
      WAIT_LOCK: busy = 1'b1;
      RUN:       video_ready = 1'b1;
      DRAIN:     begin video_ready = 1'b1; busy = 1'b1; end
      default:   gen_rst = 1'b1;
    endcase
  end

  // Timers self-clear whenever their owning state is not active, so the
  // RESET exit and IDLE entry clears need no separate handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt        <= '0;
      lock_cnt    <= '0;
      wdog        <= '0;
      pending     <= '0;
      mode_sel    <= '0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      rcnt     <= (state == RESET && next == RESET) ? rcnt + RC_W'(1) : '0;
      lock_cnt <= (enable && state == WAIT_LOCK) ? lock_cnt + LK_W'(vs_edge) : '0;
      wdog     <= (enable && watched && !vs_edge && !wd_last) ? wdog + WD_W'(1) : '0;

      if (enable && vs_edge && (state == RUN || state == DRAIN))
        frame_cnt <= frame_cnt + CNT_W'(1);

      if (enable && state == IDLE)
        mode_sel <= mode_req;
      else if (enable && state == DRAIN && (vs_edge || wd_last))
        mode_sel <= pending;

      if (stb_take && (state == DRAIN || (state == RUN && mode_req != mode_sel)))
        pending <= mode_req;

      if (!enable)      timeout_err <= 1'b0;
      else if (expire)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;

  localparam int RST_CYCLES  = 4;
  localparam int LOCK_FRAMES = 2;
  localparam int TIMEOUT     = 1000;
  localparam int CNT_W       = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode_req = '0;
  logic       mode_stb = 1'b0;
  logic       err_clr = 1'b0;
  logic       vs = 1'b0;
  logic       vs_inv;

  logic             gen_rst, video_ready, busy, timeout_err;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] frame_cnt;
  logic             n_gen_rst, n_video_ready, n_busy, n_timeout_err;
  logic [1:0]       n_mode_sel;
  logic [CNT_W-1:0] n_frame_cnt;

  assign vs_inv = ~vs;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT),
    .VS_POL(1'b1), .MODE_W(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_req(mode_req), .mode_stb(mode_stb),
    .err_clr(err_clr), .vs_in(vs), .gen_rst(gen_rst), .mode_sel(mode_sel),
    .video_ready(video_ready), .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  video_timing_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT),
    .VS_POL(1'b0), .MODE_W(2), .CNT_W(CNT_W)
  ) dut_n (
    .clk(clk), .rst(rst), .enable(enable), .mode_req(mode_req), .mode_stb(mode_stb),
    .err_clr(err_clr), .vs_in(vs_inv), .gen_rst(n_gen_rst), .mode_sel(n_mode_sel),
    .video_ready(n_video_ready), .busy(n_busy), .timeout_err(n_timeout_err), .frame_cnt(n_frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus timestamps (hold end, watchdog origin).
  typedef enum int {P_OFF, P_HOLD, P_LOCK, P_LIVE, P_FLUSH} ph_t;
  ph_t    ph;
  longint cyc = 0;
  longint hold_until, wd_base;
  int     edges, m_mode, m_pend, m_frames;
  bit     m_err, prev_vs;

  function automatic bit m_gen_rst();  return ph == P_OFF || ph == P_HOLD; endfunction
  function automatic bit m_busy();     return ph == P_HOLD || ph == P_LOCK || ph == P_FLUSH; endfunction
  function automatic bit m_ready();    return ph == P_LIVE || ph == P_FLUSH; endfunction

  task automatic model_reset();
    ph = P_OFF; m_mode = 0; m_pend = 0; m_frames = 0; m_err = 0; prev_vs = 1; edges = 0;
    wd_base = 0; hold_until = 0;
  endtask

  task automatic enter_hold();
    ph = P_HOLD;
    hold_until = cyc + RST_CYCLES;
  endtask

  task automatic model_step();
    bit edge_now, watched, expired;
    edge_now = vs && !prev_vs;
    prev_vs  = vs;
    watched  = (ph == P_LOCK || ph == P_LIVE || ph == P_FLUSH);
    expired  = watched && !edge_now && (cyc - wd_base == TIMEOUT - 1);
    if (!enable) begin
      ph = P_OFF;
      m_err = 0;
    end else begin
      case (ph)
        P_OFF: begin m_mode = int'(mode_req); enter_hold(); end
        P_HOLD: if (cyc == hold_until) begin ph = P_LOCK; edges = 0; wd_base = cyc + 1; end
        P_LOCK: begin
          if (edge_now) begin
            edges++; wd_base = cyc + 1;
            if (edges == LOCK_FRAMES) ph = P_LIVE;
          end else if (expired) enter_hold();
        end
        P_LIVE: begin
          if (edge_now) begin
            m_frames = (m_frames + 1) % (1 << CNT_W); wd_base = cyc + 1;
          end else if (expired) enter_hold();
          else if (mode_stb && int'(mode_req) != m_mode) begin
            m_pend = int'(mode_req); ph = P_FLUSH;
          end
        end
        P_FLUSH: begin
          if (edge_now) begin
            m_mode = m_pend; m_frames = (m_frames + 1) % (1 << CNT_W); enter_hold();
          end else if (expired) begin
            m_mode = m_pend; enter_hold();
          end else if (mode_stb) m_pend = int'(mode_req);
        end
        default: ph = P_OFF;
      endcase
      if (expired) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  task automatic compare_all();
    chk("gen_rst", gen_rst, m_gen_rst());
    chk("busy", busy, m_busy());
    chk("video_ready", video_ready, m_ready());
    chk("mode_sel", mode_sel, m_mode);
    chk("timeout_err", timeout_err, m_err);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("inv_pol_outputs",
        {n_gen_rst, n_busy, n_video_ready, n_mode_sel, n_timeout_err, n_frame_cnt},
        {m_gen_rst(), m_busy(), m_ready(), 2'(m_mode), m_err, CNT_W'(m_frames)});
  endtask

  // Small timing generator: vs active for the last 8 cycles of each frame.
  int gcnt = 0, frame_len = 500, next_len = 500, gen_edges = 0;
  bit gen_run = 1;

  task automatic gen_step();
    bit nv;
    if (gen_rst) begin
      gcnt = 0; frame_len = next_len;
    end else if (gen_run) begin
      if (gcnt >= frame_len - 1) begin gcnt = 0; frame_len = next_len; end
      else gcnt++;
    end
    nv = gen_run && !gen_rst && (gcnt >= frame_len - 8);
    if (nv && !vs) gen_edges++;
    vs = nv;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    cyc++;
    @(negedge clk);
    compare_all();
    mode_stb = 1'b0;
    err_clr  = 1'b0;
    gen_step();
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!video_ready && n < budget) begin cycle(); n++; end
    chk("ready_wait", video_ready, 1'b1);
  endtask

  int off_left, stall_left, start_edges, n;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("reset_gen_rst", gen_rst, 1'b1);
    chk("reset_frame_cnt", frame_cnt, 0);
    repeat (6) cycle();

    // Bring-up with mode 2
    mode_req = 2'd2; enable = 1'b1;
    cycle();
    chk("bringup_mode", mode_sel, 2'd2);
    repeat (3) cycle();
    chk("bringup_hold", gen_rst, 1'b1);
    cycle();
    chk("bringup_release", gen_rst, 1'b0);
    wait_ready(3000);
    chk("bringup_busy", busy, 1'b0);

    // Mode change, overwritten during DRAIN
    repeat (100) cycle();
    mode_req = 2'd3; mode_stb = 1'b1;
    cycle();
    chk("drain_ready", video_ready, 1'b1);
    chk("drain_busy", busy, 1'b1);
    repeat (100) cycle();
    mode_req = 2'd1; mode_stb = 1'b1;
    cycle();
    n = 0;
    while (!gen_rst && n < 600) begin cycle(); n++; end
    chk("drain_restart", gen_rst, 1'b1);
    chk("drain_mode", mode_sel, 2'd1);
    wait_ready(3000);

    // Watchdog: stall generator
    gen_run = 0;
    n = 0;
    while (!timeout_err && n < 1500) begin cycle(); n++; end
    chk("wdog_err", timeout_err, 1'b1);
    chk("wdog_gen_rst", gen_rst, 1'b1);
    gen_run = 1;
    wait_ready(3000);
    err_clr = 1'b1;
    cycle();
    chk("err_clr", timeout_err, 1'b0);

    // Edge at the last watchdog count wins; one cycle later expires
    next_len = 1000;
    repeat (5000) cycle();
    chk("collide_err", timeout_err, 1'b0);
    chk("collide_ready", video_ready, 1'b1);
    next_len = 1001;
    n = 0;
    while (!timeout_err && n < 3000) begin cycle(); n++; end
    chk("late_edge_err", timeout_err, 1'b1);
    next_len = 500;
    wait_ready(4000);
    err_clr = 1'b1;
    cycle();

    // Abort during WAIT_LOCK
    enable = 1'b0; cycle(); enable = 1'b1;
    n = 0;
    while (!(busy && !gen_rst) && n < 50) begin cycle(); n++; end
    chk("reach_wait_lock", busy && !gen_rst, 1'b1);
    repeat (100) cycle();
    enable = 1'b0;
    cycle();
    chk("abort_gen_rst", gen_rst, 1'b1);
    chk("abort_ready", video_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    enable = 1'b1;
    wait_ready(3000);

    // Async reset in DRAIN
    repeat (10) cycle();
    mode_req = 2'(m_mode + 1); mode_stb = 1'b1;
    cycle();
    repeat (50) cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_gen_rst", gen_rst, 1'b1);
    chk("arst_ready", video_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_mode", mode_sel, 2'd0);
    chk("arst_frame_cnt", frame_cnt, 0);
    cycle();
    rst = 1'b0;

    // frame_cnt wrap after 17 frames from zero
    wait_ready(3000);
    start_edges = gen_edges;
    n = 0;
    while (gen_edges - start_edges < 17 && n < 10000) begin cycle(); n++; end
    cycle();
    chk("wrap_frame_cnt", frame_cnt, 4'd1);

    // Randomized traffic
    off_left = 0; stall_left = 0;
    for (int i = 0; i < 15000; i++) begin
      mode_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) mode_stb = 1'b1;
      if ($urandom_range(0, 499) == 0) err_clr = 1'b1;
      if (enable && $urandom_range(0, 2999) == 0) begin
        enable = 1'b0; off_left = $urandom_range(1, 20);
      end else if (!enable) begin
        if (off_left == 0) enable = 1'b1; else off_left--;
      end
      if (gen_run && $urandom_range(0, 4999) == 0) begin
        gen_run = 0; stall_left = $urandom_range(200, 1500);
      end else if (!gen_run) begin
        if (stall_left == 0) gen_run = 1; else stall_left--;
      end
      if ($urandom_range(0, 1999) == 0) begin
        case ($urandom_range(0, 3))
          0: next_len = 500;
          1: next_len = 1000;
          2: next_len = 1001;
          default: next_len = 300;
        endcase
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Sequences the colour-bar/video timing generator. It holds the generator in reset and releases it cleanly, then waits for the frame timing to lock. A per-frame watchdog supervises vs, and pattern/mode changes are applied only at a frame boundary. It sits between the host/control logic and the timing generator, and gates downstream consumers (scaler) through video_ready.

Parameters:
RST_CYCLES, 16, cycles gen_rst is held high in RESET (>=1)
LOCK_FRAMES, 2, vs active edges required after release before video_ready (>=1)
TIMEOUT, 3000000, max clk cycles between vs active edges (1080p frame = 2475000)
VS_POL, 1'b1, vs_in polarity: 1 active-high, 0 active-low
MODE_W, 2, width of mode select
CNT_W, 16, frame counter width

Ports:
clk  in  1  pixel clock; also the generator clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  level; 1 = run generator, 0 = force IDLE
mode_req  in  MODE_W  requested mode/pattern
mode_stb  in  1  single-cycle strobe; samples mode_req
err_clr  in  1  clears sticky timeout_err
vs_in  in  1  vs from generator, synchronous to clk
gen_rst  out  1  reset to generator, active-high
mode_sel  out  MODE_W  applied mode, stable between RESET entries
video_ready  out  1  timing locked; downstream may consume
busy  out  1  controller in RESET, WAIT_LOCK or DRAIN
timeout_err  out  1  sticky watchdog error
frame_cnt  out  CNT_W  vs active edges counted in RUN/DRAIN, wraps

Behaviour:
- Reset values: state=IDLE, gen_rst=1, mode_sel=0, pending=0, video_ready=0, busy=0, timeout_err=0, frame_cnt=0, timers=0.
- Edge detect:
  - vs_n = vs_in when VS_POL=1, else ~vs_in.
  - vs_d <= vs_n.
  - vs_edge = vs_n & ~vs_d, combinational, used the same cycle. vs_d resets to 1 so no false edge after reset.
- All outputs are decoded from registers only; no combinational input-to-output paths.
- gen_rst = 1 in IDLE and RESET. busy = 1 in RESET, WAIT_LOCK and DRAIN. video_ready = 1 in RUN and DRAIN.
- IDLE:
  - Entry: enable=1 latches mode_sel<=mode_req and goes to RESET.
  - mode_stb in IDLE is ignored; mode_req is sampled at enable.
- RESET:
  - rcnt counts 0..RST_CYCLES-1, then goes to WAIT_LOCK.
  - On exit: lock_cnt=0, wdog=0.
  - Timing: enable sampled high at cycle k gives gen_rst low from cycle k+1+RST_CYCLES.
- WAIT_LOCK:
  - Each vs_edge: lock_cnt++, wdog=0.
  - lock_cnt reaching LOCK_FRAMES goes to RUN on the next clock.
  - wdog reaching TIMEOUT-1 with no vs_edge: timeout_err<=1, go to RESET (automatic retry, mode_sel unchanged).
- RUN:
  - Each vs_edge: frame_cnt++ (wraps 2^CNT_W-1 to 0), wdog=0.
  - Watchdog expiry handled as in WAIT_LOCK.
  - mode_stb with mode_req!=mode_sel: pending<=mode_req, go to DRAIN.
  - mode_stb with mode_req==mode_sel: no action.
- DRAIN:
  - video_ready stays 1 until the frame ends.
  - At vs_edge: mode_sel<=pending, frame_cnt++, go to RESET; video_ready drops the following cycle.
  - mode_stb in DRAIN overwrites pending (last wins), including a return to the current mode (still restarts).
  - Watchdog expiry in DRAIN: mode_sel<=pending, timeout_err<=1, go to RESET.
- Priority per cycle: enable=0 (to IDLE, all timers cleared, frame_cnt held) > vs_edge > watchdog expiry > mode_stb.
  - vs_edge and expiry in the same cycle: edge wins, no error.
- timeout_err:
  - Cleared by err_clr or by leaving to IDLE.
  - A set in the same cycle as err_clr wins (remains 1).
- frame_cnt clears only on rst.
- Async rst mid-operation: immediate return to reset values; gen_rst asserts combinationally-clean from the register reset.
- Counter widths: wdog sized clog2(TIMEOUT); rcnt sized clog2(RST_CYCLES+1); lock_cnt sized clog2(LOCK_FRAMES+1).

Decomposition:
- Package video_ctrl_pkg:
  - state encoding: IDLE=0, RESET=1, WAIT_LOCK=2, RUN=3, DRAIN=4 (3 bits);
  - clog2 function;
  - default TIMEOUT/RST_CYCLES constants.
- One sub-module, vs_edge_detect: polarity correction, vs_d register and vs_edge output; reused by the scaler control.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_FRAMES=2, TIMEOUT=1000, small-timing generator with a 500-cycle frame.
- Bring-up: rst release, enable=1 at cycle 10 with mode_req=2 -> mode_sel=2 at 11; gen_rst low from cycle 15; video_ready=1 one cycle after the 2nd vs edge; busy=0 from then.
- Mode change: in RUN, mode_stb with mode_req=3 mid-frame -> video_ready stays 1 until next vs edge; then mode_sel=3, gen_rst high 4 cycles; relock after 2 frames. A second mode_stb with mode_req=1 during DRAIN -> mode_sel=1 applied instead.
- Watchdog: stop the generator's vs in RUN -> at 1000 cycles after the last edge timeout_err=1, gen_rst pulses for 4 cycles, relock occurs; err_clr -> timeout_err=0.
- Edge/timeout collision: force a vs edge exactly at wdog=999 -> no error, stays in RUN.
- frame_cnt wraps: preload frame_cnt via CNT_W=4 build, run 17 frames -> frame_cnt=1.
- Abort: enable=0 during WAIT_LOCK and async rst during DRAIN -> IDLE next cycle / immediate reset values; gen_rst=1, video_ready=0; VS_POL=0 build repeats bring-up with inverted vs.
